// File: rtl/seg_message_player.sv
// Single-digit 7-segment message player: writable character RAM, decoder,
// loop/one-shot playback with pause and a selectable tick rate.
module seg_message_player #(
    parameter int DIV_WIDTH  = 24,
    parameter int MSG_LEN    = 12,
    parameter int ACTIVE_LOW = 1,
    localparam int AW = $clog2(MSG_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          mode_loop,
    input  logic [1:0]    speed,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [4:0]    wr_char,
    output logic [7:0]    seg_out,
    output logic [AW-1:0] index,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

    localparam logic [7:0]    BLANK  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [AW-1:0] LAST   = AW'(MSG_LEN - 1);
    localparam logic [AW:0]   LEN_EXT = (AW + 1)'(MSG_LEN);

    state_t               state, state_next;
    logic [AW-1:0]        index_next;
    logic [DIV_WIDTH-1:0] prescaler, prescaler_next, limit;
    logic                 tick;
    logic [7:0]           seg_next;
    logic [4:0]           ram [MSG_LEN];

    function automatic logic [6:0] decode_char(input logic [4:0] code);
        logic [6:0] segs;
        case (code)
            5'd0:    segs = 7'h3F;
            5'd1:    segs = 7'h06;
            5'd2:    segs = 7'h5B;
            5'd3:    segs = 7'h4F;
            5'd4:    segs = 7'h66;
            5'd5:    segs = 7'h6D;
            5'd6:    segs = 7'h7D;
            5'd7:    segs = 7'h07;
            5'd8:    segs = 7'h7F;
            5'd9:    segs = 7'h6F;
            5'd10:   segs = 7'h77;
            5'd11:   segs = 7'h7C;
            5'd12:   segs = 7'h39;
            5'd13:   segs = 7'h5E;
            5'd14:   segs = 7'h79;
            5'd15:   segs = 7'h71;
            5'd16:   segs = 7'h76;
            5'd17:   segs = 7'h38;
            5'd18:   segs = 7'h73;
            5'd19:   segs = 7'h3E;
            5'd20:   segs = 7'h50;
            5'd21:   segs = 7'h54;
            5'd22:   segs = 7'h40;
            default: segs = 7'h00;
        endcase
        return segs;
    endfunction

    function automatic logic [7:0] pin_level(input logic [6:0] segs);
        logic [7:0] raw;
        raw = {1'b0, segs};
        return (ACTIVE_LOW != 0) ? ~raw : raw;
    endfunction

    // Tick threshold 2^(DIV_WIDTH-speed)-1; >= lets a faster speed fire at once
    always_comb begin
        limit = {DIV_WIDTH{1'b1}} >> speed;
        tick  = (state == PLAY) && (prescaler >= limit);
    end

    always_comb begin
        state_next     = state;
        index_next     = index;
        prescaler_next = prescaler;
        case (state)
            IDLE: begin
                index_next     = '0;
                prescaler_next = '0;
                if (run) state_next = PLAY;
            end
            PLAY: begin
                prescaler_next = tick ? '0 : prescaler + DIV_WIDTH'(1);
                if (!run) state_next = PAUSE;
                if (tick) begin
                    if (index == LAST) begin
                        index_next = '0;
                        if (!mode_loop) state_next = DONE;
                    end else begin
                        index_next = index + AW'(1);
                    end
                end
            end
            PAUSE: begin
                if (run) state_next = PLAY;
            end
            DONE: begin
                index_next     = '0;
                prescaler_next = '0;
                if (!run) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Output follows the next-state index so it changes on the same edge
        if (state_next == PLAY || state_next == PAUSE)
            seg_next = pin_level(decode_char(ram[index_next]));
        else
            seg_next = BLANK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            prescaler <= '0;
            seg_out   <= BLANK;
        end else begin
            state     <= state_next;
            index     <= index_next;
            prescaler <= prescaler_next;
            seg_out   <= seg_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) ram[i] <= 5'd31;
        end else if (wr_en && ({1'b0, wr_addr} < LEN_EXT)) begin
            ram[wr_addr] <= wr_char;
        end
    end

    assign done = (state == DONE);

endmodule

// File: tb/tb_seg_message_player.sv
// Directed bench for seg_message_player: a 4-char common-anode instance and a
// 5-char common-cathode instance sharing clock and reset.
module tb_seg_message_player;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0, mode_loop = 1'b0, wr_en = 1'b0;
    logic [1:0] speed = 2'd0, wr_addr = 2'd0;
    logic [4:0] wr_char = 5'd0;
    logic [7:0] seg_out;
    logic [1:0] index;
    logic       done;

    logic       run_b = 1'b0, mode_loop_b = 1'b0, wr_en_b = 1'b0;
    logic [1:0] speed_b = 2'd0;
    logic [2:0] wr_addr_b = 3'd0;
    logic [4:0] wr_char_b = 5'd0;
    logic [7:0] seg_b;
    logic [2:0] index_b;
    logic       done_b;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_seg [4] = '{8'h89, 8'h86, 8'hC7, 8'hC0};

    seg_message_player #(.DIV_WIDTH(4), .MSG_LEN(4), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .run(run), .mode_loop(mode_loop), .speed(speed),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .seg_out(seg_out), .index(index), .done(done)
    );

    seg_message_player #(.DIV_WIDTH(4), .MSG_LEN(5), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .reset(reset), .run(run_b), .mode_loop(mode_loop_b), .speed(speed_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_char(wr_char_b),
        .seg_out(seg_b), .index(index_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_a(input logic [1:0] a, input logic [4:0] c);
        wr_en = 1'b1; wr_addr = a; wr_char = c;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic write_b(input logic [2:0] a, input logic [4:0] c);
        wr_en_b = 1'b1; wr_addr_b = a; wr_char_b = c;
        step(1);
        wr_en_b = 1'b0;
    endtask

    task automatic test_reset;
        step(2);
        total++; if (seg_out !== 8'hFF) begin bad++; $display("FAIL rst_seg got=%h want=ff", seg_out); end
        total++; if (index !== 2'd0) begin bad++; $display("FAIL rst_index got=%0d want=0", index); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (seg_b !== 8'h00) begin bad++; $display("FAIL rst_seg_b got=%h want=00", seg_b); end
        reset = 1'b0;
        step(1);
        total++; if (seg_out !== 8'hFF) begin bad++; $display("FAIL rel_seg got=%h want=ff", seg_out); end
        total++; if (index !== 2'd0 || done !== 1'b0) begin bad++; $display("FAIL rel_state got=%0d/%b want=0/0", index, done); end
    endtask

    task automatic test_bad_addr;
        logic [7:0] exp_b [5] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h40};
        write_b(3'd0, 5'd1);
        write_b(3'd1, 5'd2);
        write_b(3'd2, 5'd3);
        write_b(3'd3, 5'd4);
        write_b(3'd4, 5'd22);
        write_b(3'd5, 5'd8);
        write_b(3'd7, 5'd8);
        total++; if (seg_b !== 8'h00) begin bad++; $display("FAIL b_idle_seg got=%h want=00", seg_b); end
        speed_b = 2'd3; mode_loop_b = 1'b0; run_b = 1'b1;
        step(1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step(2);
            total++; if (seg_b !== exp_b[k] || index_b !== 3'(k)) begin
                bad++; $display("FAIL b_char%0d got=%h/%0d want=%h/%0d", k, seg_b, index_b, exp_b[k], k);
            end
        end
        step(2);
        total++; if (done_b !== 1'b1 || seg_b !== 8'h00 || index_b !== 3'd0) begin
            bad++; $display("FAIL b_done got=%b/%h/%0d want=1/00/0", done_b, seg_b, index_b);
        end
        run_b = 1'b0;
    endtask

    task automatic test_loop;
        write_a(2'd0, 5'd16);
        write_a(2'd1, 5'd14);
        write_a(2'd2, 5'd17);
        write_a(2'd3, 5'd0);
        total++; if (seg_out !== 8'hFF) begin bad++; $display("FAIL idle_blank got=%h want=ff", seg_out); end
        mode_loop = 1'b1; speed = 2'd0; run = 1'b1;
        step(1);
        total++; if (seg_out !== 8'h89 || index !== 2'd0) begin bad++; $display("FAIL start got=%h/%0d want=89/0", seg_out, index); end
        for (int k = 0; k < 4; k++) begin
            step(15);
            total++; if (seg_out !== exp_seg[k] || index !== 2'(k)) begin
                bad++; $display("FAIL loop_hold%0d got=%h/%0d want=%h/%0d", k, seg_out, index, exp_seg[k], k);
            end
            step(1);
            total++; if (seg_out !== exp_seg[(k + 1) % 4] || index !== 2'((k + 1) % 4)) begin
                bad++; $display("FAIL loop_adv%0d got=%h/%0d want=%h/%0d", k, seg_out, index, exp_seg[(k + 1) % 4], (k + 1) % 4);
            end
        end
    endtask

    task automatic test_one_shot;
        mode_loop = 1'b0;
        for (int k = 1; k < 4; k++) begin
            step(16);
            total++; if (seg_out !== exp_seg[k] || index !== 2'(k)) begin
                bad++; $display("FAIL shot_char%0d got=%h/%0d want=%h/%0d", k, seg_out, index, exp_seg[k], k);
            end
        end
        step(15);
        total++; if (done !== 1'b0 || seg_out !== 8'hC0) begin bad++; $display("FAIL shot_last got=%b/%h want=0/c0", done, seg_out); end
        step(1);
        total++; if (done !== 1'b1 || seg_out !== 8'hFF || index !== 2'd0) begin
            bad++; $display("FAIL shot_done got=%b/%h/%0d want=1/ff/0", done, seg_out, index);
        end
        step(3);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL done_hold got=%b want=1", done); end
        run = 1'b0;
        step(1);
        total++; if (done !== 1'b0 || seg_out !== 8'hFF) begin bad++; $display("FAIL rearm got=%b/%h want=0/ff", done, seg_out); end
        run = 1'b1;
        step(1);
        total++; if (seg_out !== 8'h89 || index !== 2'd0) begin bad++; $display("FAIL restart got=%h/%0d want=89/0", seg_out, index); end
    endtask

    task automatic test_pause;
        step(16);
        step(5);
        run = 1'b0;
        step(20);
        total++; if (seg_out !== 8'h86 || index !== 2'd1 || done !== 1'b0) begin
            bad++; $display("FAIL pause_hold got=%h/%0d want=86/1", seg_out, index);
        end
        run = 1'b1;
        step(1);
        step(9);
        total++; if (index !== 2'd1) begin bad++; $display("FAIL resume_early got=%0d want=1", index); end
        step(1);
        total++; if (index !== 2'd2 || seg_out !== 8'hC7) begin bad++; $display("FAIL resume_tick got=%h/%0d want=c7/2", seg_out, index); end
    endtask

    task automatic test_speed;
        speed = 2'd2;
        step(3);
        total++; if (index !== 2'd2) begin bad++; $display("FAIL spd2_hold got=%0d want=2", index); end
        step(1);
        total++; if (index !== 2'd3 || seg_out !== 8'hC0) begin bad++; $display("FAIL spd2_tick got=%h/%0d want=c0/3", seg_out, index); end
        mode_loop = 1'b1;
        step(4);
        total++; if (index !== 2'd0 || seg_out !== 8'h89) begin bad++; $display("FAIL spd2_wrap got=%h/%0d want=89/0", seg_out, index); end
        speed = 2'd0;
        step(9);
        speed = 2'd3;
        step(1);
        total++; if (index !== 2'd1 || seg_out !== 8'h86) begin bad++; $display("FAIL spd_switch got=%h/%0d want=86/1", seg_out, index); end
        step(1);
        total++; if (index !== 2'd1) begin bad++; $display("FAIL spd3_hold got=%0d want=1", index); end
        step(1);
        total++; if (index !== 2'd2) begin bad++; $display("FAIL spd3_tick got=%0d want=2", index); end
        step(2);
        total++; if (index !== 2'd3 || seg_out !== 8'hC0) begin bad++; $display("FAIL spd3_tick2 got=%h/%0d want=c0/3", seg_out, index); end
    endtask

    task automatic test_write_displayed;
        speed = 2'd0;
        write_a(2'd3, 5'd22);
        total++; if (seg_out !== 8'hC0) begin bad++; $display("FAIL wr_latency got=%h want=c0", seg_out); end
        step(1);
        total++; if (seg_out !== 8'hBF || index !== 2'd3) begin bad++; $display("FAIL wr_update got=%h/%0d want=bf/3", seg_out, index); end
    endtask

    task automatic test_async_reset;
        reset = 1'b1;
        #2;
        total++; if (seg_out !== 8'hFF || index !== 2'd0 || done !== 1'b0) begin
            bad++; $display("FAIL async_rst got=%h/%0d/%b want=ff/0/0", seg_out, index, done);
        end
        step(1);
        reset = 1'b0;
        step(1);
        total++; if (seg_out !== 8'hFF || index !== 2'd0) begin bad++; $display("FAIL ram_cleared0 got=%h/%0d want=ff/0", seg_out, index); end
        step(16);
        total++; if (seg_out !== 8'hFF || index !== 2'd1) begin bad++; $display("FAIL ram_cleared1 got=%h/%0d want=ff/1", seg_out, index); end
    endtask

    initial begin
        test_reset();
        test_bad_addr();
        test_loop();
        test_one_shot();
        test_pause();
        test_speed();
        test_write_displayed();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
